ex_mdu: RTL and testbench

- Execute-stage consumer of the decode stage's output bundle: aluop, alusel, reg1, reg2, wd and wreg.
- Computes logic, shift and move results and owns the HI/LO register pair.
- Runs a 32-iteration signed/unsigned divider and requests a pipeline stall while it is busy.
- Result outputs are combinational. The decode stage forwards from them in the same cycle, and the EX/MEM register captures them.

---
 rtl/ex_mdu.sv | 236 +++++++++++++++++++++++
 tb/tb_ex_mdu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// Execute stage: logic/shift/move results, HI/LO register pair and a restoring divider.
// Latency: results are combinational (zero cycles); a divide takes 33 stall cycles then 1 DONE cycle (1 stall cycle on divide-by-zero).
// Backpressure: stallreq_o holds the upstream pipeline while a divide is in flight; cancel_i aborts it without touching HI/LO.
module ex_mdu #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic              cancel_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_LUI  = 8'h5C;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MOVN = 8'h0B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam int SH_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quo;        // dividend shifts out of here, quotient bits shift in
  logic [DATA_W-1:0] rem;        // partial remainder
  logic [DATA_W-1:0] dvsr;       // divisor magnitude
  logic [DATA_W-1:0] dvnd_raw;   // untouched dividend, returned in HI on divide-by-zero
  logic              neg_q;
  logic              neg_r;
  logic              dvz;

  logic              is_div;
  logic              is_signed_div;
  logic              stall_raw;
  logic              div_start;
  logic              div_step;
  logic              div_wr;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] res;
  logic [SH_W-1:0]   shamt;

  assign is_div        = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed_div = (aluop_i == OP_DIV);
  assign shamt         = reg1_i[SH_W-1:0];

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Divider next state, stall request and datapath controls
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    div_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_div) begin
          stall_raw = 1'b1;
          div_start = 1'b1;
          state_nxt = (reg2_i == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cancel_i) begin
          state_nxt = S_IDLE;
        end else begin
          stall_raw = 1'b1;
          div_step  = 1'b1;
          if (cnt == CNT_W'(DIV_CYCLES - 1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Stall is released so the divide leaves ID/EX; results commit at this edge.
        state_nxt = S_IDLE;
        div_wr    = !cancel_i;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring shift-subtract step: a clear borrow bit means the divisor fits.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[DATA_W]) begin
      rem_nxt = diff[DATA_W-1:0];
      quo_nxt = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[DATA_W-1:0];
      quo_nxt = {quo[DATA_W-2:0], 1'b0};
    end
  end

  // Divider operand latch and iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      dvnd_raw <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvz      <= 1'b0;
    end else if (div_start) begin
      cnt      <= '0;
      rem      <= '0;
      dvnd_raw <= reg1_i;
      dvz      <= (reg2_i == '0);
      neg_q    <= is_signed_div && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
      neg_r    <= is_signed_div && reg1_i[DATA_W-1];
      quo      <= (is_signed_div && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
      dvsr     <= (is_signed_div && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
    end else if (div_step) begin
      cnt      <= cnt + CNT_W'(1);
      rem      <= rem_nxt;
      quo      <= quo_nxt;
    end
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
  end

  // HI/LO: divide completion has priority; MTHI/MTLO cannot coincide with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_wr) begin
      if (dvz) begin
        lo <= '1;
        hi <= dvnd_raw;
      end else begin
        lo <= q_fix;
        hi <= r_fix;
      end
    end else begin
      if (aluop_i == OP_MTHI) hi <= reg1_i;
      if (aluop_i == OP_MTLO) lo <= reg1_i;
    end
  end

  // Zero-latency result mux; any unlisted class/op pair yields zero.
  always_comb begin
    res = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  res = reg1_i & reg2_i;
          OP_OR:   res = reg1_i | reg2_i;
          OP_XOR:  res = reg1_i ^ reg2_i;
          OP_NOR:  res = ~(reg1_i | reg2_i);
          OP_LUI:  res = {reg2_i[DATA_W-17:0], 16'h0000};
          default: res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  res = reg2_i << shamt;
          OP_SRL:  res = reg2_i >> shamt;
          OP_SRA:  res = DATA_W'($signed(reg2_i) >>> shamt);
          default: res = '0;
        endcase
      end
      SEL_NOP: begin
        case (aluop_i)
          OP_MOVZ, OP_MOVN: res = reg1_i;
          OP_MFHI:          res = hi;
          OP_MFLO:          res = lo;
          default:          res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

  // Outputs forced to zero while reset is held.
  always_comb begin
    wdata_o    = rst ? '0 : res;
    wd_o       = rst ? 5'd0 : wd_i;
    wreg_o     = rst ? 1'b0 : wreg_i;
    stallreq_o = rst ? 1'b0 : stall_raw;
    hi_o       = hi;
    lo_o       = lo;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed vectors, a per-cycle reference model and literal spot checks.
module tb_ex_mdu;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_LUI  = 8'h5C;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MOVN = 8'h0B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        cancel;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  ex_mdu #(.DATA_W(32), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .cancel_i   (cancel),
    .wdata_o    (wdata_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .stallreq_o (stallreq_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one instruction, from the opcode table.
  function automatic logic [31:0] exp_res(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
    logic [31:0] r;
    r = 32'h0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) r = a & b;
      if (op == OP_OR)  r = a | b;
      if (op == OP_XOR) r = a ^ b;
      if (op == OP_NOR) r = ~(a | b);
      if (op == OP_LUI) r = {b[15:0], 16'h0000};
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) r = b << a[4:0];
      if (op == OP_SRL) r = b >> a[4:0];
      if (op == OP_SRA) r = $signed(b) >>> a[4:0];
    end else if (sel == SEL_NOP) begin
      if (op == OP_MOVZ || op == OP_MOVN) r = a;
      if (op == OP_MFHI) r = h;
      if (op == OP_MFLO) r = l;
    end
    return r;
  endfunction

  // Reference model: HI/LO values, plus a divide in flight described only by
  // its final result and how many stall cycles remain before it commits.
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic [31:0] m_q, m_r;
  logic        m_active = 1'b0;
  int          m_wait = 0;
  logic [31:0] e_wdata;
  logic        e_stall;
  logic        e_commit;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wdata", wdata_o, 32'h0);
      chk("rst_wd", 32'(wd_o), 32'h0);
      chk("rst_wreg", 32'(wreg_o), 32'h0);
      chk("rst_stall", 32'(stallreq_o), 32'h0);
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);
      m_hi = 32'h0;
      m_lo = 32'h0;
      m_active = 1'b0;
      m_wait = 0;
    end else begin
      e_wdata  = exp_res(aluop, alusel, reg1, reg2, m_hi, m_lo);
      e_stall  = 1'b0;
      e_commit = 1'b0;
      if (!m_active) begin
        if (aluop == OP_DIV || aluop == OP_DIVU) begin
          e_stall  = 1'b1;
          m_active = 1'b1;
          m_wait   = (reg2 == 32'h0) ? 0 : 32;
          if (reg2 == 32'h0) begin
            m_q = 32'hFFFF_FFFF;
            m_r = reg1;
          end else if (aluop == OP_DIVU) begin
            m_q = reg1 / reg2;
            m_r = reg1 % reg2;
          end else if (reg1 == 32'h8000_0000 && reg2 == 32'hFFFF_FFFF) begin
            m_q = 32'h8000_0000;
            m_r = 32'h0;
          end else begin
            m_q = $signed(reg1) / $signed(reg2);
            m_r = $signed(reg1) % $signed(reg2);
          end
        end
      end else if (m_wait > 0) begin
        if (cancel) m_active = 1'b0;
        else begin
          e_stall = 1'b1;
          m_wait--;
        end
      end else begin
        m_active = 1'b0;
        e_commit = !cancel;
      end
      chk("wdata", wdata_o, e_wdata);
      chk("wd", 32'(wd_o), 32'(wd));
      chk("wreg", 32'(wreg_o), 32'(wreg));
      chk("stall", 32'(stallreq_o), 32'(e_stall));
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      if (e_commit) begin
        m_hi = m_r;
        m_lo = m_q;
      end else begin
        if (aluop == OP_MTHI) m_hi = reg1;
        if (aluop == OP_MTLO) m_lo = reg1;
      end
    end
  end

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic w);
    aluop  = op;
    alusel = sel;
    reg1   = a;
    reg2   = b;
    wd     = d;
    wreg   = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a divide, count stall cycles up to the DONE cycle, then check HI/LO after the commit edge.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    set_in(op, SEL_NOP, a, b, 5'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      n++;
    end
    chk("div_stall_cycles", 32'(n), 32'(exp_stall));
    tick();
    chk("div_lo", lo_o, exp_lo);
    chk("div_hi", hi_o, exp_hi);
  endtask

  initial begin
    cancel = 1'b0;
    set_in(OP_DIV, SEL_NOP, 32'd7, 32'd2, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_gated", 32'(stallreq_o), 32'h0);
    chk("reset_wd_gated", 32'(wd_o), 32'h0);
    set_in(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;
    tick();

    set_in(OP_OR, SEL_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd1, 1'b1);
    #1 chk("or_lit", wdata_o, 32'h0000_FFFF);
    tick();
    set_in(OP_LUI, SEL_LOGIC, 32'h0, 32'h0000_1234, 5'd2, 1'b1);
    #1 chk("lui_lit", wdata_o, 32'h1234_0000);
    tick();
    set_in(OP_AND, SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd3, 1'b1); tick();
    set_in(OP_XOR, SEL_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd4, 1'b1); tick();
    set_in(OP_NOR, SEL_LOGIC, 32'h1234_0000, 32'h0000_5678, 5'd5, 1'b1); tick();
    set_in(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd6, 1'b1);
    #1 chk("sra_lit", wdata_o, 32'hF800_0000);
    tick();
    set_in(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd7, 1'b1);
    #1 chk("srl_lit", wdata_o, 32'h0800_0000);
    tick();
    set_in(OP_SLL, SEL_SHIFT, 32'd31, 32'h0000_0003, 5'd8, 1'b1); tick();
    set_in(OP_SLL, SEL_LOGIC, 32'd4, 32'h0000_00F1, 5'd9, 1'b1);
    #1 chk("bad_combo_zero", wdata_o, 32'h0);
    tick();

    set_in(OP_MTHI, SEL_NOP, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0); tick();
    set_in(OP_MFHI, SEL_NOP, 32'h0, 32'h0, 5'd10, 1'b1);
    #1 chk("mfhi_lit", wdata_o, 32'hDEAD_BEEF);
    chk("hi_lit", hi_o, 32'hDEAD_BEEF);
    tick();
    set_in(OP_MTLO, SEL_NOP, 32'h1357_9BDF, 32'h0, 5'd0, 1'b0); tick();
    set_in(OP_MFLO, SEL_NOP, 32'h0, 32'h0, 5'd11, 1'b1); tick();
    set_in(OP_MOVN, SEL_NOP, 32'hA5A5_0001, 32'h1, 5'd12, 1'b1); tick();
    set_in(OP_MOVZ, SEL_NOP, 32'h0BAD_F00D, 32'h0, 5'd13, 1'b0); tick();

    run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div(OP_DIVU, 32'd7,         32'd2,        33, 32'd3,        32'd1);
    run_div(OP_DIVU, 32'd5,         32'd0,        1,  32'hFFFF_FFFF, 32'd5);
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0);
    run_div(OP_DIV,  32'd100,       32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2);
    set_in(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();

    // Abort in BUSY iteration 10: HI/LO keep the previous divide's result.
    set_in(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
    tick();
    repeat (10) tick();
    cancel = 1'b1;
    #1 chk("cancel_stall_drop", 32'(stallreq_o), 32'h0);
    tick();
    cancel = 1'b0;
    set_in(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 chk("cancel_hi_kept", hi_o, 32'd2);
    chk("cancel_lo_kept", lo_o, 32'hFFFF_FFF2);
    chk("cancel_idle_stall", 32'(stallreq_o), 32'h0);
    tick();

    // Reset asserted mid-BUSY, between clock edges.
    set_in(OP_DIV, SEL_NOP, 32'd50, 32'd7, 5'd9, 1'b1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1 chk("arst_wdata", wdata_o, 32'h0);
    chk("arst_wd", 32'(wd_o), 32'h0);
    chk("arst_wreg", 32'(wreg_o), 32'h0);
    chk("arst_stall", 32'(stallreq_o), 32'h0);
    chk("arst_hi", hi_o, 32'h0);
    chk("arst_lo", lo_o, 32'h0);
    tick();
    set_in(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;
    tick();

    run_div(OP_DIVU, 32'd9, 32'd4, 33, 32'd2, 32'd1);
    set_in(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
